// File: rtl/spw_fct_pkg.sv
// Shared constants and FSM encoding for the SpaceWire receive-side FCT scheduler.
package spw_fct_pkg;

  localparam int unsigned FCT_SIZE   = 8;
  localparam int unsigned MAX_CREDIT = 56;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCheck = 2'd1,
    StReq   = 2'd2
  } fct_state_e;

endpackage

// File: rtl/rx_occupancy_cnt.sv
// Saturating up/down counter of N-chars held in the RX FIFO, with synchronous flush.
module rx_occupancy_cnt #(
  parameter int unsigned AWIDTH = 6
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [AWIDTH:0] occupancy_o,
  output logic            full_o
);

  localparam logic [AWIDTH:0] DepthC = {1'b1, {AWIDTH{1'b0}}};

  logic [AWIDTH:0] occ_q, occ_d;

  always_comb begin
    occ_d = occ_q;
    // Flush wins over any same-cycle write/read strobe.
    if (flush_i) begin
      occ_d = '0;
    end else if (inc_i && !dec_i && (occ_q != DepthC)) begin
      occ_d = occ_q + 1'b1;
    end else if (dec_i && !inc_i && (occ_q != '0)) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy_o = occ_q;
  assign full_o      = (occ_q == DepthC);

endmodule

// File: rtl/rx_fct_credit_ctrl.sv
// Receive-side FCT scheduler: tracks granted credit and FIFO occupancy, requests FCTs.
// Build option RX_CREDIT_ERR_STICKY_EN makes credit_error latch until reset or link_run falls.
module rx_fct_credit_ctrl
  import spw_fct_pkg::*;
#(
  parameter int unsigned AWIDTH = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              link_run,
  input  logic              fifo_flush,
  input  logic              rx_nchar_wr,
  input  logic              rx_nchar_rd,
  input  logic              fct_ack,
  output logic              fct_req,
  output logic [AWIDTH-1:0] credit,
  output logic [AWIDTH:0]   occupancy,
  output logic              credit_error
);

  // Two spare bits keep the grant sum from ever wrapping.
  localparam int unsigned     CW     = AWIDTH + 2;
  localparam logic [CW-1:0]   DepthW = CW'(2 ** AWIDTH);
  localparam logic [CW-1:0]   FctW   = CW'(FCT_SIZE);
  localparam logic [CW-1:0]   MaxW   = CW'(MAX_CREDIT);
  localparam logic [CW-1:0]   LimitW = CW'(MAX_CREDIT - FCT_SIZE);

  fct_state_e        state_q, state_d;
  logic              fct_req_q, fct_req_d;
  logic [AWIDTH-1:0] credit_q, credit_d;
  logic              err_q, err_d;
  logic              occ_full;
  logic              ack_ok;
  logic              grant_ok;
  logic              err_event;
  logic [CW-1:0]     occ_w, cred_w, cred_n;

  rx_occupancy_cnt #(
    .AWIDTH(AWIDTH)
  ) u_occ (
    .clk_i       (clock),
    .rst_ni      (reset),
    .flush_i     (fifo_flush),
    .inc_i       (rx_nchar_wr),
    .dec_i       (rx_nchar_rd),
    .occupancy_o (occupancy),
    .full_o      (occ_full)
  );

  assign occ_w     = CW'(occupancy);
  assign cred_w    = CW'(credit_q);
  assign ack_ok    = fct_ack && (state_q == StReq);
  assign grant_ok  = ((occ_w + cred_w + FctW) <= DepthW) && (cred_w <= LimitW);
  assign err_event = rx_nchar_wr && (((credit_q == '0) && !ack_ok) || occ_full);

  always_comb begin
    state_d = state_q;
    if (!link_run) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  state_d = StCheck;
        StCheck: if (grant_ok) state_d = StReq;
        StReq:   if (fct_ack) state_d = StCheck;
        default: state_d = StIdle;
      endcase
    end
    fct_req_d = (state_d == StReq);
  end

  always_comb begin
    cred_n = cred_w;
    if (ack_ok) begin
      cred_n = cred_n + FctW;
    end
    // An N-char arriving with nothing granted leaves credit at zero.
    if (rx_nchar_wr && (cred_n != '0)) begin
      cred_n = cred_n - 1'b1;
    end
    if (cred_n > MaxW) begin
      cred_n = MaxW;
    end
    if (!link_run) begin
      cred_n = '0;
    end
    credit_d = cred_n[AWIDTH-1:0];
  end

`ifdef RX_CREDIT_ERR_STICKY_EN
  logic link_run_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      link_run_q <= 1'b0;
    end else begin
      link_run_q <= link_run;
    end
  end

  // A new offence in the cycle link_run falls still latches.
  always_comb begin
    err_d = err_event || (err_q && !(link_run_q && !link_run));
  end
`else
  always_comb begin
    err_d = err_event;
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      fct_req_q <= 1'b0;
      credit_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      fct_req_q <= fct_req_d;
      credit_q  <= credit_d;
      err_q     <= err_d;
    end
  end

  assign fct_req      = fct_req_q;
  assign credit       = credit_q;
  assign credit_error = err_q;

endmodule

// File: tb/tb_rx_fct_credit_ctrl.sv
// Self-checking bench for rx_fct_credit_ctrl: directed scenarios plus random traffic vs a model.
module tb_rx_fct_credit_ctrl;

  localparam int Depth = 64;
  localparam int Fct   = 8;
  localparam int MaxCr = 56;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       link_run = 1'b0;
  logic       fifo_flush = 1'b0;
  logic       rx_nchar_wr = 1'b0;
  logic       rx_nchar_rd = 1'b0;
  logic       fct_ack = 1'b0;
  logic       fct_req;
  logic [5:0] credit;
  logic [6:0] occupancy;
  logic       credit_error;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain counts and two flags (link up, request pending).
  int m_credit = 0;
  int m_occ    = 0;
  bit m_up     = 0;
  bit m_req    = 0;
  bit m_err    = 0;
  bit m_prev_run = 0;

  rx_fct_credit_ctrl #(
    .AWIDTH(6)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .link_run     (link_run),
    .fifo_flush   (fifo_flush),
    .rx_nchar_wr  (rx_nchar_wr),
    .rx_nchar_rd  (rx_nchar_rd),
    .fct_ack      (fct_ack),
    .fct_req      (fct_req),
    .credit       (credit),
    .occupancy    (occupancy),
    .credit_error (credit_error)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".fct_req"}, int'(fct_req), int'(m_req));
    check_eq({tag, ".credit"}, int'(credit), m_credit);
    check_eq({tag, ".occupancy"}, int'(occupancy), m_occ);
    check_eq({tag, ".credit_error"}, int'(credit_error), int'(m_err));
  endtask

  // Apply one cycle of inputs, advance the model across the edge, then compare.
  task automatic step(input bit wr, input bit rd, input bit ack, input bit run, input bit flush,
                      input string tag);
    bit ack_hit;
    bit offence;
    int free_slots;
    rx_nchar_wr = wr;
    rx_nchar_rd = rd;
    fct_ack     = ack;
    link_run    = run;
    fifo_flush  = flush;
    @(posedge clock);
    ack_hit    = ack && m_req;
    offence    = wr && ((m_credit == 0 && !ack_hit) || m_occ == Depth);
    free_slots = Depth - m_occ - m_credit;
    if (!run) begin
      m_up  = 0;
      m_req = 0;
    end else if (!m_up) begin
      m_up = 1;
    end else if (m_req) begin
      if (ack) m_req = 0;
    end else if (free_slots >= Fct && m_credit <= MaxCr - Fct) begin
      m_req = 1;
    end
    if (!run) m_credit = 0;
    else if (ack_hit && wr) m_credit = m_credit + Fct - 1;
    else if (ack_hit) m_credit = m_credit + Fct;
    else if (wr && m_credit > 0) m_credit = m_credit - 1;
    if (m_credit > MaxCr) m_credit = MaxCr;
    if (flush) m_occ = 0;
    else if (wr && !rd && m_occ < Depth) m_occ++;
    else if (rd && !wr && m_occ > 0) m_occ--;
`ifdef RX_CREDIT_ERR_STICKY_EN
    m_err = offence || (m_err && !(m_prev_run && !run));
`else
    m_err = offence;
`endif
    m_prev_run = run;
    #1;
    check_all(tag);
  endtask

  initial begin
    int handshakes;
    int budget;
    int occ_before;
    bit seen_req;

    repeat (3) @(posedge clock);
    #1;
    check_all("reset");
    reset = 1'b1;

    // 1: empty FIFO, ack every request -> seven FCTs, credit 56.
    handshakes = 0;
    for (int i = 0; i < 60; i++) begin
      if (m_req && fct_req) handshakes++;
      step(0, 0, m_req, 1, 0, "s1");
    end
    check_eq("s1_handshakes", handshakes, 7);
    check_eq("s1_credit_max", int'(credit), 56);

    // 2: eight writes, eight reads -> exactly one new FCT.
    for (int i = 0; i < 8; i++) step(1, 0, 0, 1, 0, "s2_wr");
    check_eq("s2_credit_after_wr", int'(credit), 48);
    handshakes = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_req && fct_req) handshakes++;
      step(0, 1, m_req, 1, 0, "s2_rd");
    end
    for (int i = 0; i < 10; i++) begin
      if (m_req && fct_req) handshakes++;
      step(0, 0, m_req, 1, 0, "s2_idle");
    end
    check_eq("s2_handshakes", handshakes, 1);
    check_eq("s2_credit", int'(credit), 56);
    check_eq("s2_occ", int'(occupancy), 0);

    // 3: credit forced to zero by link drop, then one write -> error.
    step(0, 0, 0, 0, 0, "s3_down");
    step(0, 0, 0, 0, 0, "s3_down");
    step(1, 0, 0, 0, 0, "s3_wr");
    check_eq("s3_err_set", int'(credit_error), 1);
    check_eq("s3_credit_zero", int'(credit), 0);
    check_eq("s3_occ_one", int'(occupancy), 1);
    step(0, 0, 0, 0, 0, "s3_after");
`ifdef RX_CREDIT_ERR_STICKY_EN
    check_eq("s3_err_sticky", int'(credit_error), 1);
`else
    check_eq("s3_err_pulse", int'(credit_error), 0);
`endif

    // 4: build credit 16, spend down to 10 with request pending, then ack with a write.
    budget = 0;
    while (m_credit < 16 && budget < 100) begin
      step(0, 0, m_req, 1, 0, "s4_fill");
      budget++;
    end
    check_eq("s4_fill_timeout", int'(budget < 100), 1);
    budget = 0;
    while ((m_credit > 10 || !m_req) && budget < 100) begin
      step(m_credit > 10, 0, 0, 1, 0, "s4_spend");
      budget++;
    end
    check_eq("s4_spend_timeout", int'(budget < 100), 1);
    step(1, 0, 1, 1, 0, "s4_ackwr");
    check_eq("s4_credit17", int'(credit), 17);
    occ_before = m_occ;
    step(1, 1, 0, 1, 0, "s4_wrrd");
    check_eq("s4_occ_same", int'(occupancy), occ_before);

    // 5: drop link_run while a request is held.
    budget = 0;
    while (!m_req && budget < 50) begin
      step(0, 0, 0, 1, 0, "s5_wait");
      budget++;
    end
    check_eq("s5_req_timeout", int'(fct_req), 1);
    occ_before = m_occ;
    step(0, 0, 0, 0, 0, "s5_drop");
    check_eq("s5_req_low", int'(fct_req), 0);
    check_eq("s5_credit_zero", int'(credit), 0);
    check_eq("s5_occ_kept", int'(occupancy), occ_before);
    step(0, 0, 0, 0, 1, "s5_flush");
    check_eq("s5_occ_flushed", int'(occupancy), 0);

    // 6: fill to 60, clear credit, confirm no request until reads free 8 slots.
    budget = 0;
    while (m_occ < 60 && budget < 600) begin
      step(m_credit > 0, 0, m_req, 1, 0, "s6_fill");
      budget++;
    end
    check_eq("s6_fill_timeout", int'(budget < 600), 1);
    step(0, 0, 0, 0, 0, "s6_down");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, "s6_up");
    check_eq("s6_no_req", int'(fct_req), 0);
    seen_req = 0;
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 0, "s6_rd");
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0, "s6_wait");
      if (fct_req) seen_req = 1;
    end
    check_eq("s6_req_after_rd", int'(seen_req), 1);

    // Random traffic, including spurious acks, link drops and flushes.
    for (int i = 0; i < 3000; i++) begin
      bit wr, rd, ack, run, flush;
      wr    = ($urandom_range(99) < 35);
      rd    = ($urandom_range(99) < 35);
      ack   = m_req ? bit'($urandom_range(1)) : ($urandom_range(9) == 0);
      run   = ($urandom_range(149) != 0);
      flush = ($urandom_range(299) == 0);
      step(wr, rd, ack, run, flush, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
